// File: rtl/scan_mux_if.sv
// rtl/scan_mux_if.sv - load, select and serial-bit port bundle for scan_mux
interface scan_mux_if #(
  parameter int WIDTH = 36,
  parameter int SEL_W = 6
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] scan_start;
  logic [SEL_W-1:0] scan_last;
  logic             step;
  logic             y;
  logic             y_valid;
  logic             scan_done;

  modport master (
    output load_valid, load_data, mode, sel, scan_start, scan_last, step,
    input  load_ready, y, y_valid, scan_done
  );

  modport slave (
    input  load_valid, load_data, mode, sel, scan_start, scan_last, step,
    output load_ready, y, y_valid, scan_done
  );
endinterface

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - double-buffered registered bit selector with auto-scan
module scan_mux #(
  parameter int WIDTH = 36,
  parameter int SEL_W = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  scan_mux_if.slave  bus
);
  typedef enum logic {EMPTY, ACTIVE} state_t;

  localparam logic [SEL_W-1:0] TOP_IDX = SEL_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, active_q;
  logic             shadow_full_q;
  logic [SEL_W-1:0] idx_q, last_q;
  logic             y_q, y_valid_q, scan_done_q;

  logic             accept, retire, promote, advance;
  logic             y_d, y_valid_d;
  logic             sel_bit, idx_bit;
  logic [SEL_W-1:0] last_in, idx_next;

  // Mask-and-reduce gives 0 for any index past WIDTH-1 without a range compare.
  assign sel_bit  = |(active_q & (ONE << bus.sel));
  assign idx_bit  = |(active_q & (ONE << idx_q));
  assign last_in  = (bus.scan_last > TOP_IDX) ? TOP_IDX : bus.scan_last;
  assign idx_next = (idx_q == TOP_IDX) ? '0 : idx_q + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (shadow_full_q) state_d = ACTIVE;
      ACTIVE:  if (retire && !shadow_full_q) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    accept    = bus.load_valid && !shadow_full_q;
    retire    = 1'b0;
    advance   = 1'b0;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    if (state_q == ACTIVE) begin
      if (!bus.mode) begin
        y_d       = sel_bit;
        y_valid_d = 1'b1;
        retire    = bus.step;
      end else if (bus.step) begin
        y_d       = idx_bit;
        y_valid_d = 1'b1;
        if (idx_q == last_q) retire  = 1'b1;
        else                 advance = 1'b1;
      end
    end else begin
      y_d       = 1'b0;
      y_valid_d = 1'b0;
    end
    promote = shadow_full_q && ((state_q == EMPTY) || retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      active_q      <= '0;
      idx_q         <= '0;
      last_q        <= '0;
      y_q           <= 1'b0;
      y_valid_q     <= 1'b0;
      scan_done_q   <= 1'b0;
    end else begin
      if (accept) shadow_q <= bus.load_data;
      // Promotion only happens with the shadow full, so it never races an accept.
      if (promote)     shadow_full_q <= 1'b0;
      else if (accept) shadow_full_q <= 1'b1;
      if (promote) begin
        active_q <= shadow_q;
        idx_q    <= bus.scan_start;
        last_q   <= last_in;
      end else if (advance) begin
        idx_q    <= idx_next;
      end
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      scan_done_q <= retire;
    end
  end

  assign bus.load_ready = !shadow_full_q;
  assign bus.y          = y_q;
  assign bus.y_valid    = y_valid_q;
  assign bus.scan_done  = scan_done_q;
endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised, registered bit-selector with a double-buffered input word and an auto-scan mode. It serialises a WIDTH-bit word (pattern row, glyph slice, sprite line) onto one registered output bit for the VGA pixel path. In direct mode it is a registered WIDTH:1 mux; in scan mode it walks an index range one bit per `step`. A ready/valid port queues the next word while the current one is being emitted.

## Interface
- `WIDTH`, 36, number of selectable data bits (2..64)
- `SEL_W`, 6, index width; 2^SEL_W >= WIDTH required
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `load_valid` in 1: `load_data` offered
- `load_ready` out 1: shadow buffer empty, load accepted when both high
- `load_data` in WIDTH: word to queue
- `mode` in 1: 0 = direct select, 1 = scan
- `sel` in SEL_W: direct-mode index
- `scan_start` in SEL_W: first scan index, sampled at promotion
- `scan_last` in SEL_W: final scan index, sampled at promotion
- `step` in 1: advance / retire strobe
- `y` out 1: registered selected bit
- `y_valid` out 1: `y` carries a bit of an active word
- `scan_done` out 1: one-cycle pulse, active word retired

## Operation
- Storage: `shadow` + `shadow_full`; `active` + state; `idx` (SEL_W); latched `last` (SEL_W).
- States: EMPTY (no active word), ACTIVE.
- Load: `load_ready = !shadow_full` (registered, no same-cycle bypass). Accept writes `shadow`, sets `shadow_full`.
- Promotion: in EMPTY with `shadow_full`, next cycle active <= shadow, `shadow_full` <= 0, `idx` <= `scan_start`, `last` <= `scan_last`, state -> ACTIVE.
- Retire → promotion in the same edge if `shadow_full`, else state -> EMPTY. `scan_done` pulses on every retire.
- Direct mode (ACTIVE): each cycle `y` <= `active[sel]`, `y_valid` <= 1. `step` retires the word after that cycle's output.
- Scan mode (ACTIVE): on `step`, `y` <= `active[idx]`, `y_valid` <= 1. If `idx == last`, retire; else `idx` <= `idx`+1, wrapping from WIDTH-1 to 0. Without `step`, `y`/`y_valid` hold.
- Wrap: `scan_start > scan_last` scans start..WIDTH-1, 0..last.
- Out-of-range index (`sel` or `idx` >= WIDTH): `y` <= 0, `y_valid` still 1. A `last` >= WIDTH is treated as WIDTH-1.
- EMPTY: `y` <= 0, `y_valid` <= 0; `step` ignored, no `scan_done`.
- `mode` sampled every cycle; switching mid-scan keeps `idx`/`last` and resumes scanning on return to mode 1.

## Timing
- Reset (async assert, sync release): state EMPTY, `shadow_full`=0, `idx`=0, `y`=0, `y_valid`=0, `scan_done`=0, `load_ready`=1. Reset mid-scan discards both words.
- Load accepted at edge N: `load_ready` low from N. If EMPTY, promoted at N+1 and `load_ready` high again from N+1.
- Output latency: one cycle from `sel`/`step` to `y`.
- Scan of L bits with `step` held high: `y_valid` at N+1..N+L, `scan_done` coincident with the edge producing the last bit.
- Back-to-back with shadow full: next word's first bit on the cycle after `scan_done`; no gap in `y_valid`.
- Load and retire in same cycle with shadow full: load not accepted (`load_ready`=0); shadow promotes, `load_ready` rises next cycle.

## Test plan
- Reset: drive `rst_n`=0 mid-scan → `y`=0, `y_valid`=0, `load_ready`=1 immediately; after release no `scan_done` until a new load.
- Direct: load 36'h8_0000_0001, mode 0, `sel`=0,1,35,40 → `y`=1,0,1,0 one cycle later each, `y_valid`=1.
- Scan: load 36'h0_0000_00A5, start 0, last 7, `step`=1 → `y`=1,0,1,0,0,1,0,1 on 8 consecutive cycles, `scan_done` with the 8th.
- Wrap: load 36'h8_0000_0003, start 34, last 1 → `y`=0,1,1,1 (indices 34,35,0,1), then `scan_done`.
- Double buffer: queue word B during word A's scan → `load_ready` low until B promoted; B's first bit immediately follows `scan_done` of A, `y_valid` continuous.
- Stall: toggle `step` 1,0,0,1 during scan → `y` holds during zeros, `idx` advances only on ones.
